control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
Multicycle RISC-V RV32I main control unit. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath mux selects and write enables. Supplies `alu_op` (alu_op_t) directly to ALUdecoder, which combines it with funct3/funct7 to produce `alu_control`.

Parameters:
None (opcode encodings are fixed RV32I values).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
opcode  in  7  instr[6:0] from the instruction register
mem_ready  in  1  unified memory has completed the current access this cycle
alu_op  out  alu_op_t  to ALUdecoder
alu_src_a  out  2  00 pc, 01 old_pc, 10 rd1, 11 zero
alu_src_b  out  2  00 rd2, 01 imm, 10 constant 4
result_src  out  2  00 alu_out (registered), 01 mem data, 10 alu_result (combinational)
adr_src  out  1  0 pc, 1 result
ir_write  out  1  latch instruction and old_pc
pc_update  out  1  unconditional PC write
branch  out  1  conditional PC write; datapath qualifies it with the ALU flag
mem_write  out  1  memory write strobe
reg_write  out  1  register file write
instr_done  out  1  one-cycle pulse on the last state of every instruction

Behaviour:
- Moore FSM with one registered state. Outputs are decoded from state; `ir_write`, `pc_update` in FETCH and `mem_write` are additionally gated as noted below.
- Reset (reset==0 at a rising edge): state <= FETCH. While reset is low, all enables (`ir_write`, `pc_update`, `branch`, `mem_write`, `reg_write`, `instr_done`) are forced to 0 and `alu_op` = ALU_OP__ADD. Reset mid-instruction abandons the instruction with no further writes.
- Any output not listed for a state is 0 / don't-care-driven-to-00, and `alu_op` defaults to ALU_OP__ADD.
- FETCH: adr_src=0, src_a=00, src_b=10, ADD, result_src=10. ir_write=pc_update=mem_ready. Stays in FETCH while mem_ready==0; otherwise goes to DECODE.
- DECODE: src_a=01, src_b=01, ADD (precomputes the branch/JAL target into alu_out). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode -> FETCH with instr_done=1 (treated as a NOP)
- MEMADR: src_a=10, src_b=01, ADD. Goes to MEMREAD if opcode==0000011, otherwise to MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Holds until mem_ready; instr_done=mem_ready; then goes to FETCH.
- EXECUTER: src_a=10, src_b=00, ALU_OP__REGISTER_OPERATION. Goes to ALUWB.
- EXECUTEI: src_a=10, src_b=01, ALU_OP__UNSET (the I-type encoding expected by ALUdecoder). Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
- BRANCH: src_a=10, src_b=00, ALU_OP__BRANCH, result_src=00, branch=1, instr_done=1. Goes to FETCH.
- JAL: result_src=00, pc_update=1, src_a=01, src_b=10, ADD. Goes to ALUWB.
- JALR: src_a=10, src_b=01, ADD, result_src=10, pc_update=1. Goes to LINK.
- LINK: src_a=01, src_b=10, ADD. Goes to ALUWB.
- LUI: src_a=11, src_b=01, ADD. Goes to ALUWB.
- AUIPC: src_a=01, src_b=01, ADD. Goes to ALUWB.
- Cycle counts with mem_ready tied high:
  - R/I/LUI/AUIPC: 4
  - branch: 3
  - load: 5
  - store: 4
  - JAL: 4
  - JALR: 5
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored elsewhere.

Optional Feature:
CONTROL_FSM_ILLEGAL_TRAP_EN
- Defined: adds output `illegal_instr` (1 bit) and state TRAP. An unrecognised opcode in DECODE goes to TRAP instead of FETCH. TRAP asserts illegal_instr=1 with all enables 0, and the FSM stays in TRAP until reset.
- Undefined: no `illegal_instr` port and no TRAP state. Unrecognised opcodes retire as NOPs (DECODE -> FETCH, instr_done=1).

Test Plan:
- Hold reset low 3 cycles with mem_ready=1 -> all enables 0 and alu_op=ALU_OP__ADD; first cycle after release is FETCH with ir_write=pc_update=1.
- opcode=0110011, mem_ready=1 -> state sequence FETCH, DECODE, EXECUTER (alu_op=ALU_OP__REGISTER_OPERATION), ALUWB (reg_write=1, instr_done=1); next FETCH at cycle 5.
- opcode=0000011 with mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> ir_write fires only on the ready cycle; reg_write asserts in MEMWB; 10 cycles total.
- opcode=0100011 with mem_ready low 1 cycle in MEMWRITE -> mem_write high for exactly 2 cycles with adr_src=1; reg_write is never asserted.
- opcode=1100011 -> BRANCH state shows alu_op=ALU_OP__BRANCH, branch=1, src_a=10, src_b=00; opcode=1100111 -> JALR pc_update=1 with result_src=10, then LINK, then ALUWB reg_write=1.
- opcode=1111111 -> with the macro undefined: DECODE -> FETCH, instr_done=1. With CONTROL_FSM_ILLEGAL_TRAP_EN: illegal_instr=1 held for 10 cycles, no enables asserted; reset low returns to FETCH.

Source files
------------

// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - ALU op encoding and control bundle between control_fsm and the datapath (CONTROL_FSM_ILLEGAL_TRAP_EN adds illegal_instr)
package control_fsm_pkg;
    typedef enum logic [1:0] {
        ALU_OP__ADD                = 2'b00,
        ALU_OP__BRANCH             = 2'b01,
        ALU_OP__REGISTER_OPERATION = 2'b10,
        ALU_OP__UNSET              = 2'b11
    } alu_op_t;
endpackage

interface control_fsm_if;
    import control_fsm_pkg::*;

    logic [6:0] opcode;
    logic       mem_ready;
    alu_op_t    alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       instr_done;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        input  opcode,
        input  mem_ready,
        output alu_op,
        output alu_src_a,
        output alu_src_b,
        output result_src,
        output adr_src,
        output ir_write,
        output pc_update,
        output branch,
        output mem_write,
        output reg_write,
        output instr_done
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        ,
        output illegal_instr
`endif
    );

    modport slave (
        output opcode,
        output mem_ready,
        input  alu_op,
        input  alu_src_a,
        input  alu_src_b,
        input  result_src,
        input  adr_src,
        input  ir_write,
        input  pc_update,
        input  branch,
        input  mem_write,
        input  reg_write,
        input  instr_done
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        ,
        input  illegal_instr
`endif
    );
endinterface

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle RV32I main control FSM (CONTROL_FSM_ILLEGAL_TRAP_EN adds TRAP state)
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master ctrl
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_LUI,
        S_AUIPC
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        ctrl.alu_op     = ALU_OP__ADD;
        ctrl.alu_src_a  = 2'b00;
        ctrl.alu_src_b  = 2'b00;
        ctrl.result_src = 2'b00;
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.pc_update  = 1'b0;
        ctrl.branch     = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.instr_done = 1'b0;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        ctrl.illegal_instr = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.ir_write   = ctrl.mem_ready;
                ctrl.pc_update  = ctrl.mem_ready;
                if (ctrl.mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form old_pc + imm so BRANCH/JAL find their target in alu_out.
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                case (ctrl.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        state_next      = S_FETCH;
                        ctrl.instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                state_next = (ctrl.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (ctrl.mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = ctrl.mem_ready;
                if (ctrl.mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALU_OP__REGISTER_OPERATION;
                state_next     = S_ALUWB;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_OP__UNSET;
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 2'b10;
                ctrl.alu_op     = ALU_OP__BRANCH;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from alu_out while the ALU forms the link address.
                ctrl.pc_update = 1'b1;
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                state_next     = S_ALUWB;
            end
            S_JALR: begin
                ctrl.alu_src_a  = 2'b10;
                ctrl.alu_src_b  = 2'b01;
                ctrl.result_src = 2'b10;
                ctrl.pc_update  = 1'b1;
                state_next      = S_LINK;
            end
            S_LINK: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                state_next     = S_ALUWB;
            end
            S_LUI: begin
                ctrl.alu_src_a = 2'b11;
                ctrl.alu_src_b = 2'b01;
                state_next     = S_ALUWB;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                state_next     = S_ALUWB;
            end
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal_instr = 1'b1;
                state_next         = S_TRAP;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset abandons any in-flight instruction: no writes may escape.
        if (!reset) begin
            ctrl.alu_op     = ALU_OP__ADD;
            ctrl.ir_write   = 1'b0;
            ctrl.pc_update  = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - directed-vector bench for control_fsm
module tb_control_fsm;
    import control_fsm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    control_fsm_if bus ();

    control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {bus.ir_write, bus.pc_update, bus.branch, bus.mem_write, bus.reg_write,
                  bus.instr_done, bus.alu_op, bus.alu_src_a, bus.alu_src_b,
                  bus.result_src, bus.adr_src};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] ctl(input logic ir, input logic pcu, input logic br,
                                        input logic mw, input logic rw, input logic done,
                                        input logic [1:0] aop, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [1:0] rs,
                                        input logic adr);
        return {ir, pcu, br, mw, rw, done, aop, sa, sb, rs, adr};
    endfunction

    function automatic logic [14:0] w_fetch(input logic mr);
        return ctl(mr, mr, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b10, 2'b10, 0);
    endfunction

    function automatic logic [14:0] w_decode(input logic done);
        return ctl(0, 0, 0, 0, 0, done, ALU_OP__ADD, 2'b01, 2'b01, 2'b00, 0);
    endfunction

    function automatic logic [14:0] w_aluwb();
        return ctl(0, 0, 0, 0, 1, 1, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 0);
    endfunction

    function automatic logic [14:0] w_memadr();
        return ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b10, 2'b01, 2'b00, 0);
    endfunction

    // Apply mem_ready for the current cycle, check the decoded outputs, advance one clock.
    task automatic cyc(input string tag, input logic mr, input logic [14:0] exp);
        bus.mem_ready = mr;
        #1;
        check_eq(tag, {17'd0, obs}, {17'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 7'b0110011;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc("reset_hold", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b10, 2'b10, 0));
        end
        reset = 1'b1;

        // R-type
        cyc("r_fetch", 1, w_fetch(1));
        cyc("r_decode", 0, w_decode(0));
        cyc("r_exec", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__REGISTER_OPERATION, 2'b10, 2'b00, 2'b00, 0));
        cyc("r_aluwb", 1, w_aluwb());

        // Load with memory wait states in FETCH and MEMREAD
        bus.opcode = 7'b0000011;
        cyc("ld_fetch_w0", 0, w_fetch(0));
        cyc("ld_fetch_w1", 0, w_fetch(0));
        cyc("ld_fetch", 1, w_fetch(1));
        cyc("ld_decode", 1, w_decode(0));
        cyc("ld_memadr", 1, w_memadr());
        for (int i = 0; i < 3; i++) begin
            cyc("ld_memread_w", 0, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 1));
        end
        cyc("ld_memread", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 1));
        cyc("ld_memwb", 1, ctl(0, 0, 0, 0, 1, 1, ALU_OP__ADD, 2'b00, 2'b00, 2'b01, 0));

        // Store with one wait state in MEMWRITE
        bus.opcode = 7'b0100011;
        cyc("st_fetch", 1, w_fetch(1));
        cyc("st_decode", 1, w_decode(0));
        cyc("st_memadr", 1, w_memadr());
        cyc("st_memwr_w", 0, ctl(0, 0, 0, 1, 0, 0, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 1));
        cyc("st_memwr", 1, ctl(0, 0, 0, 1, 0, 1, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 1));

        // Branch
        bus.opcode = 7'b1100011;
        cyc("br_fetch", 1, w_fetch(1));
        cyc("br_decode", 1, w_decode(0));
        cyc("br_branch", 0, ctl(0, 0, 1, 0, 0, 1, ALU_OP__BRANCH, 2'b10, 2'b00, 2'b00, 0));

        // JALR
        bus.opcode = 7'b1100111;
        cyc("jalr_fetch", 1, w_fetch(1));
        cyc("jalr_decode", 1, w_decode(0));
        cyc("jalr_jalr", 1, ctl(0, 1, 0, 0, 0, 0, ALU_OP__ADD, 2'b10, 2'b01, 2'b10, 0));
        cyc("jalr_link", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b01, 2'b10, 2'b00, 0));
        cyc("jalr_aluwb", 1, w_aluwb());

        // JAL
        bus.opcode = 7'b1101111;
        cyc("jal_fetch", 1, w_fetch(1));
        cyc("jal_decode", 1, w_decode(0));
        cyc("jal_jal", 1, ctl(0, 1, 0, 0, 0, 0, ALU_OP__ADD, 2'b01, 2'b10, 2'b00, 0));
        cyc("jal_aluwb", 1, w_aluwb());

        // I-type, LUI, AUIPC
        bus.opcode = 7'b0010011;
        cyc("i_fetch", 1, w_fetch(1));
        cyc("i_decode", 1, w_decode(0));
        cyc("i_exec", 0, ctl(0, 0, 0, 0, 0, 0, ALU_OP__UNSET, 2'b10, 2'b01, 2'b00, 0));
        cyc("i_aluwb", 1, w_aluwb());
        bus.opcode = 7'b0110111;
        cyc("lui_fetch", 1, w_fetch(1));
        cyc("lui_decode", 1, w_decode(0));
        cyc("lui_lui", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b11, 2'b01, 2'b00, 0));
        cyc("lui_aluwb", 1, w_aluwb());
        bus.opcode = 7'b0010111;
        cyc("auipc_fetch", 1, w_fetch(1));
        cyc("auipc_decode", 1, w_decode(0));
        cyc("auipc_auipc", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b01, 2'b01, 2'b00, 0));
        cyc("auipc_aluwb", 1, w_aluwb());

        // Reset during a stalled store suppresses mem_write and restarts at FETCH
        bus.opcode = 7'b0100011;
        cyc("rst_st_fetch", 1, w_fetch(1));
        cyc("rst_st_decode", 1, w_decode(0));
        cyc("rst_st_memadr", 1, w_memadr());
        reset = 1'b0;
        cyc("rst_st_memwr", 0, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 1));
        reset = 1'b1;
        cyc("rst_st_refetch", 1, w_fetch(1));

        // Unrecognised opcode
        bus.opcode = 7'b1111111;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        cyc("ill_decode", 1, w_decode(0));
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            check_eq("trap_illegal", {31'd0, bus.illegal_instr}, 32'd1);
            check_eq("trap_outputs", {17'd0, obs},
                     {17'd0, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 0)});
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        cyc("trap_rst", 1, ctl(0, 0, 0, 0, 0, 0, ALU_OP__ADD, 2'b00, 2'b00, 2'b00, 0));
        reset = 1'b1;
        bus.opcode = 7'b0110011;
        #1;
        check_eq("trap_cleared", {31'd0, bus.illegal_instr}, 32'd0);
        cyc("trap_refetch", 1, w_fetch(1));
`else
        cyc("nop_decode", 1, w_decode(1));
        bus.opcode = 7'b0110011;
        cyc("nop_refetch", 1, w_fetch(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
